// File: rtl/delaybuffer_arbiter.sv
// Round-robin arbiter that funnels NumReq ready/valid producers into one registered
// output stage feeding a shared delay buffer. Optional grant counters: DELAYARB_STATS_EN.
module delaybuffer_arbiter #(
    parameter int NumReq    = 4,
    parameter int DataWidth = 8,
    parameter int IdWidth   = $clog2(NumReq)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [NumReq*DataWidth-1:0] req_data_i,
    input  logic [NumReq-1:0]           req_valid_i,
    output logic [NumReq-1:0]           req_ready_o,
    output logic                        valid_o,
    output logic [DataWidth-1:0]        data_o,
    output logic [IdWidth-1:0]          id_o,
    input  logic                        ready_i
`ifdef DELAYARB_STATS_EN
    ,
    input  logic [IdWidth-1:0]          stat_sel_i,
    output logic [15:0]                 stat_cnt_o
`endif
);

    logic                 load;
    logic                 any_valid;
    logic                 transfer;
    logic [IdWidth-1:0]   ptr_q;
    logic [IdWidth-1:0]   gnt;
    logic [IdWidth-1:0]   ptr_next;
    logic [DataWidth-1:0] req_data [NumReq];

    assign load      = !valid_o || ready_i;
    assign any_valid = |req_valid_i;
    // Ready is forced low while reset is held so no producer sees a phantom handshake.
    assign transfer  = load && any_valid && !reset_i;

    genvar gi;
    generate
        for (gi = 0; gi < NumReq; gi++) begin : g_req
            assign req_data[gi]    = req_data_i[gi*DataWidth +: DataWidth];
            assign req_ready_o[gi] = transfer && (gnt == IdWidth'(gi));
        end
    endgenerate

    // Walk the indices from the farthest back to ptr_q so the nearest valid one wins.
    always_comb begin
        int                 idx;
        logic [IdWidth-1:0] idx_w;
        gnt   = '0;
        idx   = 0;
        idx_w = '0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= NumReq) begin
                idx = idx - NumReq;
            end
            idx_w = IdWidth'(idx);
            if (req_valid_i[idx_w]) begin
                gnt = idx_w;
            end
        end
    end

    // Wrap against NumReq-1 so non-power-of-two sizes never reach unused indices.
    assign ptr_next = (gnt == IdWidth'(NumReq - 1)) ? '0 : gnt + 1'b1;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            id_o    <= '0;
            ptr_q   <= '0;
        end else if (transfer) begin
            valid_o <= 1'b1;
            data_o  <= req_data[gnt];
            id_o    <= gnt;
            ptr_q   <= ptr_next;
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end
    end

`ifdef DELAYARB_STATS_EN
    logic [15:0] cnt_q [NumReq];

    generate
        for (gi = 0; gi < NumReq; gi++) begin : g_cnt
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    cnt_q[gi] <= '0;
                end else if (req_ready_o[gi] && cnt_q[gi] != 16'hFFFF) begin
                    cnt_q[gi] <= cnt_q[gi] + 16'd1;
                end
            end
        end
    endgenerate

    assign stat_cnt_o = (int'(stat_sel_i) < NumReq) ? cnt_q[stat_sel_i] : 16'h0000;
`endif

endmodule

// File: tb/tb_delaybuffer_arbiter.sv
// Randomized and directed bench for delaybuffer_arbiter: a 4-requester and a 3-requester
// instance are each tracked by a queue-free round-robin reference model.
module tb_delaybuffer_arbiter;

    localparam int N4 = 4;
    localparam int N3 = 3;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [N4*DW-1:0] d4;
    logic [N4-1:0]    v4, r4;
    logic             ov4, rdy4;
    logic [DW-1:0]    od4;
    logic [1:0]       oid4;

    logic [N3*DW-1:0] d3;
    logic [N3-1:0]    v3, r3;
    logic             ov3, rdy3;
    logic [DW-1:0]    od3;
    logic [1:0]       oid3;

`ifdef DELAYARB_STATS_EN
    logic [1:0]  ssel4, ssel3;
    logic [15:0] scnt4, scnt3;
`endif

    delaybuffer_arbiter #(.NumReq(N4), .DataWidth(DW)) dut4 (
        .clk_i(clk), .reset_i(rst), .req_data_i(d4), .req_valid_i(v4), .req_ready_o(r4),
        .valid_o(ov4), .data_o(od4), .id_o(oid4), .ready_i(rdy4)
`ifdef DELAYARB_STATS_EN
        , .stat_sel_i(ssel4), .stat_cnt_o(scnt4)
`endif
    );

    delaybuffer_arbiter #(.NumReq(N3), .DataWidth(DW)) dut3 (
        .clk_i(clk), .reset_i(rst), .req_data_i(d3), .req_valid_i(v3), .req_ready_o(r3),
        .valid_o(ov3), .data_o(od3), .id_o(oid3), .ready_i(rdy3)
`ifdef DELAYARB_STATS_EN
        , .stat_sel_i(ssel3), .stat_cnt_o(scnt3)
`endif
    );

    int vectors = 0;
    int errors  = 0;

    // Reference state: what the output stage must hold, and where priority starts.
    int e4_valid, e4_data, e4_id, e4_ptr;
    int e3_valid, e3_data, e3_id, e3_ptr;
    int cnt4 [N4];
    int cnt3 [N3];

    bit rand3;
    bit seen_r02;
    int id_log[$];
    int data_log[$];
    int id3_log[$];
    int data3_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // First valid index when searching ptr, ptr+1, ... modulo n; -1 when none.
    function automatic int rr_pick(input int n, input int ptr, input logic [15:0] v);
        for (int k = 0; k < n; k++) begin
            if (v[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    task automatic model_reset();
        e4_valid = 0; e4_data = 0; e4_id = 0; e4_ptr = 0;
        e3_valid = 0; e3_data = 0; e3_id = 0; e3_ptr = 0;
        foreach (cnt4[i]) cnt4[i] = 0;
        foreach (cnt3[i]) cnt3[i] = 0;
    endtask

    // One clock: settle, compare everything against the model, then advance the model.
    task automatic cycle();
        int g4, g3;
        logic [N4-1:0] er4;
        logic [N3-1:0] er3;
        if (rand3) begin
            v3   = N3'($urandom);
            d3   = (N3*DW)'($urandom);
            rdy3 = ($urandom_range(0, 3) != 0);
        end
        #1;
        g4  = rr_pick(N4, e4_ptr, 16'(v4));
        g3  = rr_pick(N3, e3_ptr, 16'(v3));
        er4 = '0;
        er3 = '0;
        if (!rst && (e4_valid == 0 || rdy4) && g4 >= 0) er4[g4] = 1'b1;
        if (!rst && (e3_valid == 0 || rdy3) && g3 >= 0) er3[g3] = 1'b1;
        chk("valid4", 32'(ov4), e4_valid);
        chk("data4",  32'(od4), e4_data);
        chk("id4",    32'(oid4), e4_id);
        chk("ready4", 32'(r4), 32'(er4));
        chk("valid3", 32'(ov3), e3_valid);
        chk("data3",  32'(od3), e3_data);
        chk("id3",    32'(oid3), e3_id);
        chk("ready3", 32'(r3), 32'(er3));
        if (ov4) begin
            id_log.push_back(int'(oid4));
            data_log.push_back(int'(od4));
        end
        if (ov3) begin
            id3_log.push_back(int'(oid3));
            data3_log.push_back(int'(od3));
        end
        seen_r02 = seen_r02 | r4[0] | r4[2];
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (er4 != 0) begin
                e4_valid = 1; e4_data = int'(d4[g4*DW +: DW]); e4_id = g4; e4_ptr = (g4 + 1) % N4;
                if (cnt4[g4] < 65535) cnt4[g4]++;
            end else if (rdy4) begin
                e4_valid = 0;
            end
            if (er3 != 0) begin
                e3_valid = 1; e3_data = int'(d3[g3*DW +: DW]); e3_id = g3; e3_ptr = (g3 + 1) % N3;
                if (cnt3[g3] < 65535) cnt3[g3]++;
            end else if (rdy3) begin
                e3_valid = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_logs();
        id_log.delete(); data_log.delete(); id3_log.delete(); data3_log.delete();
    endtask

    initial begin
        rst = 1'b1; rand3 = 1'b0; seen_r02 = 1'b0;
        d4 = '0; v4 = '0; rdy4 = 1'b0;
        d3 = '0; v3 = '0; rdy3 = 1'b0;
`ifdef DELAYARB_STATS_EN
        ssel4 = 2'd0; ssel3 = 2'd0;
`endif
        model_reset();
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;

        // All four busy with 10+i; the 3-wide instance takes req 2 then req 0 out of reset.
        d4 = {8'h13, 8'h12, 8'h11, 8'h10};
        v4 = 4'hF; rdy4 = 1'b1;
        d3 = {8'h22, 8'h21, 8'h20}; rdy3 = 1'b1;
        clear_logs();
        v3 = 3'b100; cycle();
        v3 = 3'b001; cycle();
        v3 = 3'b000;
        for (int i = 0; i < 5; i++) cycle();
        chk("busy_count", 32'(id_log.size() >= 5), 1);
        for (int i = 0; i < 5 && i < id_log.size(); i++) begin
            chk("busy_id",   32'(id_log[i]), i % 4);
            chk("busy_data", 32'(data_log[i]), 32'h10 + (i % 4));
        end
        chk("wrap3_count", 32'(id3_log.size()), 2);
        if (id3_log.size() >= 2) begin
            chk("wrap3_first_id",    32'(id3_log[0]), 2);
            chk("wrap3_first_data",  32'(data3_log[0]), 32'h22);
            chk("wrap3_second_id",   32'(id3_log[1]), 0);
            chk("wrap3_second_data", 32'(data3_log[1]), 32'h20);
        end

        // Sparse: only 1 and 3 request; ids must alternate and 0/2 never see ready.
        rand3 = 1'b1;
        v4 = 4'b1010;
        cycle();
        clear_logs();
        seen_r02 = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        chk("sparse_never_r02", 32'(seen_r02), 0);
        for (int i = 1; i < id_log.size(); i++) begin
            chk("sparse_in_set", 32'(id_log[i] == 1 || id_log[i] == 3), 1);
            chk("sparse_alternates", 32'(id_log[i] != id_log[i-1]), 1);
        end

        // Backpressure with a full stage for 5 cycles, then release.
        v4 = 4'hF;
        cycle();
        rdy4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("hold_ready_zero", 32'(r4), 0);
            chk("hold_valid", 32'(ov4), 1);
        end
        rdy4 = 1'b1;
        cycle();
        cycle();

        // Random traffic on both instances.
        for (int i = 0; i < 3000; i++) begin
            v4   = N4'($urandom);
            d4   = (N4*DW)'($urandom);
            rdy4 = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // Asynchronous reset mid-stream with the stage full.
        v4 = 4'hF; rdy4 = 1'b1; cycle();
        rdy4 = 1'b0; cycle();
        rdy4 = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("reset_valid_async", 32'(ov4), 0);
        chk("reset_id_async",    32'(oid4), 0);
        chk("reset_ready_async", 32'(r4), 0);
        chk("reset_data_async",  32'(od4), 0);
        chk("reset_valid3_async", 32'(ov3), 0);
        model_reset();
        @(negedge clk);
        cycle();
        rst = 1'b0;
        v4 = 4'b1010;
        clear_logs();
        cycle();
        cycle();
        chk("post_reset_first_id", (id_log.size() > 0) ? 32'(id_log[0]) : 32'hDEAD, 1);

`ifdef DELAYARB_STATS_EN
        rst = 1'b1; model_reset(); cycle(); rst = 1'b0;
        rand3 = 1'b0; v3 = 3'b000; rdy3 = 1'b1;
        v4 = 4'b0100; rdy4 = 1'b1; d4 = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int i = 0; i < 70000; i++) cycle();
        ssel4 = 2'd2; #1;
        chk("stat_sat_req2", 32'(scnt4), 32'hFFFF);
        chk("stat_model_req2", 32'(scnt4), cnt4[2]);
        ssel4 = 2'd1; #1;
        chk("stat_req1_zero", 32'(scnt4), 0);
        ssel3 = 2'd3; #1;
        chk("stat_out_of_range", 32'(scnt3), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
